stream_mux_rr: RTL and testbench

//  Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshake and a registered output.

---
 rtl/stream_mux_pkg.sv | 15 +
 rtl/stream_mux_if.sv | 20 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/stream_mux_rr.sv | 108 ++++++++++
 tb/tb_stream_mux_rr.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the N-channel stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    // Round-robin pointer value after reset: pointing at the last channel
    // makes channel 0 the first one searched.
    function automatic int unsigned reset_ptr(input int unsigned n);
        return n - 1;
    endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Bundle of all non-clock/reset signals of stream_mux_rr.
interface stream_mux_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N     = 4
);
    import stream_mux_pkg::*;

    localparam int unsigned SELW = $clog2(N);

    mux_mode_e          mode;
    logic [SELW-1:0]    sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;

endinterface

// File: rtl/rr_arbiter.sv
// Rotate-priority round-robin arbiter with its own pointer register.
// The pointer moves to the granted channel only when 'advance' is high.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant_oh,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_vld
);

    logic [SELW-1:0] r_ptr;

    // First requesting channel searching ptr+1, ptr+2, ... with wrap-around.
    always_comb begin
        int unsigned v_idx;
        grant_oh  = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        v_idx     = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            v_idx = int'(r_ptr) + off;
            if (v_idx >= N) begin
                v_idx = v_idx - N;
            end
            if (!grant_vld && req[SELW'(v_idx)]) begin
                grant_vld              = 1'b1;
                grant_idx              = SELW'(v_idx);
                grant_oh[SELW'(v_idx)] = 1'b1;
            end
        end
    end

    // Pointer register: restarts at the last channel, follows actual transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= SELW'(reset_ptr(N));
        end else if (advance && grant_vld) begin
            r_ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with fixed or round-robin
// selection and a single-entry registered output stage.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  mux_mode_e          mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_chan;
    logic             r_out_valid;

    logic             w_load_en;
    logic [N-1:0]     w_grant_oh;
    logic [SELW-1:0]  w_grant_idx;
    logic             w_grant_vld;
    logic             w_advance;
    logic [N-1:0]     w_ready;
    logic             w_xfer;
    logic [SELW-1:0]  w_xfer_idx;
    logic [WIDTH-1:0] w_xfer_data;

    assign w_load_en = !r_out_valid || out_ready;

    // The arbiter always sees the requests; its pointer only moves on an
    // RR-mode transfer, so it is preserved across FIXED periods.
    assign w_advance = !rst && (mode == MODE_RR) && w_load_en;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (w_advance),
        .grant_oh  (w_grant_oh),
        .grant_idx (w_grant_idx),
        .grant_vld (w_grant_vld)
    );

    // Per-channel ready from the selected mode; nothing is ready in reset.
    always_comb begin
        w_ready    = '0;
        w_xfer_idx = '0;
        if (mode == MODE_FIXED) begin
            w_xfer_idx = sel;
            if (int'(sel) < N) begin
                w_ready[sel] = w_load_en;
            end
        end else begin
            w_xfer_idx = w_grant_idx;
            w_ready    = w_grant_oh & {N{w_load_en}};
        end
        if (rst) begin
            w_ready = '0;
        end
    end

    assign in_ready = w_ready;
    assign w_xfer   = |(in_valid & w_ready);

    // Data mux over constant slices so an out-of-range sel never indexes.
    always_comb begin
        w_xfer_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_xfer_idx == SELW'(i)) begin
                w_xfer_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register: load on transfer, drain when consumed, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_xfer_data;
                r_out_chan  <= w_xfer_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios plus random
// traffic, compared against a transaction-level reference model.
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    localparam int WIDTH = 4;
    localparam int N     = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_mux_if #(.WIDTH(WIDTH), .N(N)) bus ();

    stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (bus.mode),
        .sel       (bus.sel),
        .in_data   (bus.in_data),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .out_data  (bus.out_data),
        .out_chan  (bus.out_chan),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state: what the consumer should see, and the
    // channel that was served last in round-robin mode.
    int m_ptr   = N - 1;
    bit m_valid = 1'b0;
    int m_data  = 0;
    int m_chan  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: check ready mid-cycle, advance the model at the edge,
    // then check the registered outputs just after it.
    task automatic cycle();
        int  exp_rdy;
        int  grant;
        int  c;
        bit  load;
        bit  xfer;
        logic [N*WIDTH-1:0] d;
        exp_rdy = 0;
        grant   = -1;
        xfer    = 1'b0;
        c       = 0;
        load    = !m_valid || bus.out_ready;
        @(negedge clk);
        d = bus.in_data;
        if (!rst) begin
            if (bus.mode == MODE_FIXED) begin
                if (load && int'(bus.sel) < N) exp_rdy = 1 << bus.sel;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (grant < 0 && bus.in_valid[(m_ptr + k) % N]) grant = (m_ptr + k) % N;
                end
                if (grant >= 0 && load) exp_rdy = 1 << grant;
            end
        end
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        for (int k = 0; k < N; k++) begin
            if (exp_rdy[k] && bus.in_valid[k]) begin
                xfer = 1'b1;
                c    = k;
            end
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 0;
            m_chan  = 0;
            m_ptr   = N - 1;
        end else if (load) begin
            if (xfer) begin
                m_valid = 1'b1;
                m_data  = int'(d[c*WIDTH +: WIDTH]);
                m_chan  = c;
                if (bus.mode == MODE_RR) m_ptr = c;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out_data", 32'(bus.out_data), 32'(m_data));
        check("out_chan", 32'(bus.out_chan), 32'(m_chan));
    endtask

    task automatic do_reset(input int cycles);
        rst          = 1'b1;
        bus.in_valid = '1;
        bus.mode     = MODE_RR;
        bus.out_ready = 1'b1;
        repeat (cycles) cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.mode      = MODE_RR;
        bus.sel       = '0;
        bus.in_data   = 16'h4321;
        bus.in_valid  = '1;
        bus.out_ready = 1'b1;
        #1;

        // Reset with all channels valid; first RR grant must be ch0.
        do_reset(2);
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        cycle();
        check("first_grant", 32'(bus.out_chan), 32'd0);

        // FIXED sel=2 with ch2 carrying A.
        bus.mode     = MODE_FIXED;
        bus.sel      = 2'd2;
        bus.in_data  = 16'h0A00;
        bus.in_valid = 4'b0100;
        cycle();
        check("fixed_ready", 32'(bus.in_ready), 32'b0100);
        check("fixed_data", 32'(bus.out_data), 32'hA);
        check("fixed_chan", 32'(bus.out_chan), 32'd2);

        // RR with all valid: 0,1,2,3,0,1,2,3 back-to-back.
        do_reset(1);
        bus.in_valid = '1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 16'($urandom);
            cycle();
            check("rr_seq", 32'(bus.out_chan), 32'(i % N));
            check("rr_valid", 32'(bus.out_valid), 32'd1);
        end

        // Backpressure: outputs hold, then the sequence resumes at ch0.
        bus.out_ready = 1'b0;
        repeat (3) begin
            bus.in_data = 16'($urandom);
            cycle();
            check("stall_chan", 32'(bus.out_chan), 32'd3);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("resume_seq", 32'(bus.out_chan), 32'(i));
        end

        // Sparse wrap from ptr=3 with only ch1/ch3 valid.
        bus.in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("sparse_seq", 32'(bus.out_chan), (i == 1) ? 32'd3 : 32'd1);
        end

        // Mode switch keeps the RR pointer.
        do_reset(1);
        bus.in_valid = '1;
        cycle();
        check("sw_g0", 32'(bus.out_chan), 32'd0);
        cycle();
        check("sw_g1", 32'(bus.out_chan), 32'd1);
        bus.mode = MODE_FIXED;
        bus.sel  = 2'd3;
        cycle();
        check("sw_fixed", 32'(bus.out_chan), 32'd3);
        bus.mode = MODE_RR;
        cycle();
        check("sw_back_rr", 32'(bus.out_chan), 32'd2);
        bus.mode     = MODE_FIXED;
        bus.in_valid = 4'b0111;
        cycle();
        check("fixed_no_valid", 32'(bus.out_valid), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 39) == 0);
            bus.mode      = mux_mode_e'($urandom_range(0, 3) != 0);
            bus.sel       = 2'($urandom);
            bus.in_data   = 16'($urandom);
            bus.in_valid  = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
